// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register and one-entry skid buffer.
// Single outstanding req/gnt/rvalid fetch; redirects flush and refetch.
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = 'h13
) (
    input  logic            clk,
    input  logic            n_rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] word;
        logic [XLEN-1:0] pc;
    } if_id_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            kill_q, kill_d;
    logic            run_q;
    if_id_t          ifid_q, ifid_d;
    if_id_t          skid_q, skid_d;

    logic            slot_free;
    logic            accept;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] target_pc;
    logic [1:0]      unused_low;

    assign unused_low = redirect_pc[1:0];
    assign slot_free  = !ifid_q.valid || !stall;
    assign accept     = imem_req && imem_gnt;
    assign next_pc    = fetch_pc_q + XLEN'(4);
    assign target_pc  = {redirect_pc[XLEN-1:2], 2'b00};

    // run_q keeps the request low until the first edge after reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            kill_q     <= 1'b0;
            run_q      <= 1'b0;
            ifid_q     <= '{valid: 1'b0, word: NOP_INSTR, pc: '0};
            skid_q     <= '{valid: 1'b0, word: NOP_INSTR, pc: '0};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            kill_q     <= kill_d;
            run_q      <= 1'b1;
            ifid_q     <= ifid_d;
            skid_q     <= skid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_q;
        ifid_d     = ifid_q;
        skid_d     = skid_q;
        imem_req   = 1'b0;

        if (!stall) begin
            ifid_d.valid = 1'b0;
            ifid_d.word  = NOP_INSTR;
        end

        unique case (state_q)
            S_REQ: begin
                imem_req = run_q && slot_free;
                if (accept) begin
                    fetch_pc_d = pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (slot_free) begin
                        ifid_d  = '{valid: 1'b1, word: imem_rdata,
                                    pc: fetch_pc_q};
                        pc_d    = next_pc;
                        state_d = S_REQ;
                    end else begin
                        skid_d  = '{valid: 1'b1, word: imem_rdata,
                                    pc: fetch_pc_q};
                        pc_d    = next_pc;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    ifid_d       = skid_q;
                    skid_d.valid = 1'b0;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // a taken branch beats stall and any data returning this cycle
        if (redirect) begin
            pc_d         = target_pc;
            ifid_d.valid = 1'b0;
            ifid_d.word  = NOP_INSTR;
            skid_d.valid = 1'b0;
            unique case (state_q)
                S_REQ: begin
                    if (accept) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    assign imem_addr   = {pc_q[XLEN-1:2], 2'b00};
    assign instr_valid = ifid_q.valid;
    assign instr       = ifid_q.word;
    assign instr_pc    = ifid_q.pc;
    assign opcode      = ifid_q.word[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run
// checked against an in-order instruction stream model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN(32),
        .RESET_PC(32'h0),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .opcode(opcode)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5673;
    endfunction

    // memory responder: decides gnt/rvalid 2 time units after each negedge
    bit          auto_mem = 1'b1;
    int          lat_min  = 1;
    int          lat_max  = 1;
    int          gnt_pct  = 100;
    bit          pend     = 1'b0;
    int          cnt      = 0;
    logic [31:0] paddr    = '0;
    logic        last_req = 1'b0;
    logic [31:0] last_addr = '0;

    always @(negedge clk) begin
        #2;
        if (!n_rst) begin
            pend        = 1'b0;
            last_req    = 1'b0;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
        end else if (auto_mem) begin
            imem_rvalid = 1'b0;
            if (imem_gnt && last_req) begin
                pend  = 1'b1;
                paddr = last_addr;
                cnt   = int'($urandom_range(lat_max, lat_min));
            end
            if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pend        = 1'b0;
                end
            end
            imem_gnt  = imem_req && !pend &&
                        (int'($urandom_range(99, 0)) < gnt_pct);
            last_req  = imem_req;
            last_addr = imem_addr;
        end
    end

    task automatic wait_valid(input string name, input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < max);
        n_checks++;
        if (!instr_valid) begin
            n_fail++;
            $display("FAIL %s: instr_valid=0 after %0d cycles, required 1", name, n);
        end
    endtask

    task automatic wait_req(input string name, input int max);
        int n = 0;
        while (!imem_req && n < max) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!imem_req) begin
            n_fail++;
            $display("FAIL %s: imem_req=0 after %0d cycles, required 1", name, n);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks += 5;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        if (instr !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h want %h", instr, NOP); end
        if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", instr_pc); end
        if (opcode !== 7'h13) begin n_fail++; $display("FAIL rst_opcode: got %h want 13", opcode); end
        n_rst = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", imem_req); end
        if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_basic();
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        wait_valid("basic0", 20);
        n_checks += 5;
        if (instr !== 32'h0050_0093) begin n_fail++; $display("FAIL basic0_instr: got %h want 00500093", instr); end
        if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL basic0_pc: got %h want 0", instr_pc); end
        if (opcode !== 7'h13) begin n_fail++; $display("FAIL basic0_opcode: got %h want 13", opcode); end
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL basic_next_req: got %b want 1", imem_req); end
        if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL basic_next_addr: got %h want 4", imem_addr); end
        wait_valid("basic1", 20);
        n_checks += 2;
        if (instr !== 32'h00A0_0113) begin n_fail++; $display("FAIL basic1_instr: got %h want 00a00113", instr); end
        if (instr_pc !== 32'h4) begin n_fail++; $display("FAIL basic1_pc: got %h want 4", instr_pc); end
    endtask

    task automatic test_stall();
        logic [31:0] cap;
        cap   = instr;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks += 4;
            if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, instr_valid); end
            if (instr !== cap) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want %h", i, instr, cap); end
            if (instr_pc !== 32'h4) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 4", i, instr_pc); end
            if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req); end
        end
        stall = 1'b0;
        #1;
        n_checks += 2;
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL unstall_req: got %b want 1", imem_req); end
        if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL unstall_addr: got %h want 8", imem_addr); end
        wait_valid("unstall", 20);
        n_checks += 2;
        if (instr_pc !== 32'h8) begin n_fail++; $display("FAIL unstall_pc: got %h want 8", instr_pc); end
        if (instr !== mem_word(32'h8)) begin n_fail++; $display("FAIL unstall_instr: got %h want %h", instr, mem_word(32'h8)); end
    endtask

    task automatic test_redirect_wait();
        lat_min = 3; lat_max = 3;
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_valid: got %b want 0", instr_valid); end
        wait_req("rdw_req", 20);
        n_checks++;
        if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rdw_addr: got %h want 100", imem_addr); end
        wait_valid("rdw_ret", 30);
        n_checks += 2;
        if (instr_pc !== 32'h100) begin n_fail++; $display("FAIL rdw_pc: got %h want 100", instr_pc); end
        if (instr !== mem_word(32'h100)) begin n_fail++; $display("FAIL rdw_instr: got %h want %h", instr, mem_word(32'h100)); end
    endtask

    task automatic test_redirect_rvalid();
        lat_min = 1; lat_max = 1;
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_checks += 3;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rdv_valid: got %b want 0", instr_valid); end
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rdv_req: got %b want 1", imem_req); end
        if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL rdv_addr: got %h want 200", imem_addr); end
        wait_valid("rdv_ret", 20);
        n_checks += 2;
        if (instr_pc !== 32'h200) begin n_fail++; $display("FAIL rdv_pc: got %h want 200", instr_pc); end
        if (instr !== mem_word(32'h200)) begin n_fail++; $display("FAIL rdv_instr: got %h want %h", instr, mem_word(32'h200)); end
    endtask

    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        wait_valid("wrap_top", 20);
        n_checks += 4;
        if (instr_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got %h want fffffffc", instr_pc); end
        if (instr !== mem_word(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_instr: got %h want %h", instr, mem_word(32'hFFFF_FFFC)); end
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_req: got %b want 1", imem_req); end
        if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
        wait_valid("wrap_zero", 20);
        n_checks += 2;
        if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL wrap0_pc: got %h want 0", instr_pc); end
        if (instr !== 32'h0050_0093) begin n_fail++; $display("FAIL wrap0_instr: got %h want 00500093", instr); end
    endtask

    task automatic test_reset_mid();
        lat_min = 3; lat_max = 3;
        @(negedge clk);
        auto_mem    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        #1 n_rst = 1'b0;
        #1;
        n_checks += 5;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req: got %b want 0", imem_req); end
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", instr_valid); end
        if (instr !== NOP) begin n_fail++; $display("FAIL mid_instr: got %h want %h", instr, NOP); end
        if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL mid_pc: got %h want 0", instr_pc); end
        if (opcode !== 7'h13) begin n_fail++; $display("FAIL mid_opcode: got %h want 13", opcode); end
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL mid_first_req: got %b want 1", imem_req); end
        if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_first_addr: got %h want 0", imem_addr); end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        n_checks += 3;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL late_valid: got %b want 0", instr_valid); end
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL late_req: got %b want 1", imem_req); end
        if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL late_addr: got %h want 0", imem_addr); end
        lat_min  = 1; lat_max = 1;
        auto_mem = 1'b1;
        wait_valid("mid_ret", 20);
        n_checks += 2;
        if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL mid_ret_pc: got %h want 0", instr_pc); end
        if (instr !== 32'h0050_0093) begin n_fail++; $display("FAIL mid_ret_instr: got %h want 00500093", instr); end
    endtask

    // model: delivered PCs form an in-order +4 stream restarted by each redirect
    task automatic test_random();
        logic [31:0] exp_pc = '0;
        logic [31:0] hold_instr, hold_pc, prev_rpc;
        logic        prev_valid, prev_stall, prev_redirect;
        int          deliveries = 0;
        lat_min = 1; lat_max = 3; gnt_pct = 70;
        redirect      = 1'b1;
        redirect_pc   = 32'h0000_1000 | ($urandom & 32'h0000_0FFF);
        prev_rpc      = redirect_pc;
        prev_redirect = 1'b1;
        prev_stall    = stall;
        prev_valid    = instr_valid;
        hold_instr    = instr;
        hold_pc       = instr_pc;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (prev_redirect) begin
                exp_pc = {prev_rpc[31:2], 2'b00};
                n_checks++;
                if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b want 0", i, instr_valid); end
            end else if (prev_valid && prev_stall) begin
                n_checks += 3;
                if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_hold_v[%0d]: got %b want 1", i, instr_valid); end
                if (instr !== hold_instr) begin n_fail++; $display("FAIL rnd_hold_i[%0d]: got %h want %h", i, instr, hold_instr); end
                if (instr_pc !== hold_pc) begin n_fail++; $display("FAIL rnd_hold_pc[%0d]: got %h want %h", i, instr_pc, hold_pc); end
            end else if (instr_valid) begin
                n_checks += 3;
                if (instr_pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, instr_pc, exp_pc); end
                if (instr !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, instr, mem_word(exp_pc)); end
                if (opcode !== exp_pc_op(exp_pc)) begin n_fail++; $display("FAIL rnd_op[%0d]: got %h want %h", i, opcode, exp_pc_op(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            if (!instr_valid) begin
                n_checks++;
                if (instr !== NOP) begin n_fail++; $display("FAIL rnd_nop[%0d]: got %h want %h", i, instr, NOP); end
            end
            n_checks += 2;
            if (imem_req && instr_valid && stall) begin n_fail++; $display("FAIL rnd_req_busy[%0d]: got req=1 want 0", i); end
            if (imem_addr[1:0] !== 2'b00) begin n_fail++; $display("FAIL rnd_align[%0d]: got %h want low bits 00", i, imem_addr); end
            prev_valid = instr_valid;
            hold_instr = instr;
            hold_pc    = instr_pc;
            stall      = ($urandom_range(99, 0) < 30);
            redirect   = ($urandom_range(99, 0) < 5);
            if ($urandom_range(3, 0) == 0)
                redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else
                redirect_pc = $urandom;
            prev_stall    = stall;
            prev_redirect = redirect;
            prev_rpc      = redirect_pc;
        end
        redirect = 1'b0;
        stall    = 1'b0;
        n_checks++;
        if (deliveries < 30) begin n_fail++; $display("FAIL rnd_progress: got %0d deliveries want >= 30", deliveries); end
    endtask

    function automatic logic [6:0] exp_pc_op(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return w[6:0];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_rst       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
